// File: rtl/ste_avg_pkg.sv
// Shared types and helpers for the moving-average filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ste_avg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Requested window exponent limited to what the ring buffer can hold.
  function automatic int clamp_win(input int k, input int max);
    return (k > max) ? max : k;
  endfunction

  // Accumulator width: a full window of max-valued samples never overflows.
  function automatic int sum_width(input int data_w, input int max_log2);
    return data_w + max_log2;
  endfunction

endpackage

// File: rtl/ste_avg_ringbuf.sv
// Sample history memory: one write port, one combinational read port.
// Latency: write visible the cycle after wr_vld; read is combinational.
// Backpressure: none; a write is accepted every cycle wr_vld is high.
module ste_avg_ringbuf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Store the incoming sample; contents are not reset since fill tracking masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Same-address read returns the value from before this cycle's write.
  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/ste_avg_mavg.sv
// Boxcar moving average over the last 2^k samples, k selectable at run time.
// Latency: one cycle from din_update_i to dout_o/dout_update_o; a strobe every cycle is accepted.
// Backpressure: none; strobe-driven path that never stalls, clear/window change drop a same-cycle sample.
module ste_avg_mavg
  import ste_avg_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 3,
  parameter int ROUND    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             din_i,
  input  logic                          din_update_i,
  input  logic                          avg_clr_i,
  input  logic [$clog2(MAX_LOG2+1)-1:0] win_log2_i,
  output logic [DATA_W-1:0]             dout_o,
  output logic                          dout_update_o,
  output logic                          dout_full_o
);

  localparam int WIN_W = $clog2(MAX_LOG2 + 1);
  localparam int SUM_W = sum_width(DATA_W, MAX_LOG2);
  localparam int CNT_W = MAX_LOG2 + 1;

  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [MAX_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [WIN_W-1:0]    win_q, win_d;
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_update_q, dout_update_d;
  logic                dout_full_q, dout_full_d;

  logic [WIN_W-1:0]    win_req;
  logic                win_chg;
  logic [CNT_W-1:0]    n_cnt;
  logic [MAX_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0]   rd_dat;
  logic [DATA_W-1:0]   old_dat;
  logic [SUM_W-1:0]    acc_n;
  logic [SUM_W:0]      rnd_add;
  logic [SUM_W:0]      avg_sum;
  logic                wr_vld;

  ste_avg_ringbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (MAX_LOG2)
  ) u_ringbuf (
    .clk     (clk),
    .wr_vld  (wr_vld),
    .wr_addr (wr_ptr_q),
    .wr_dat  (din_i),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  // Datapath: window size, oldest sample to retire, new sum and its scaled/rounded form.
  always_comb begin
    win_req = WIN_W'(clamp_win(int'(win_log2_i), MAX_LOG2));
    win_chg = (win_req != win_q);
    n_cnt   = CNT_W'(1) << win_q;
    // At full depth the offset wraps to zero, so the read hits the slot about to be overwritten.
    rd_addr = wr_ptr_q - n_cnt[MAX_LOG2-1:0];
    old_dat = (fill_cnt_q == n_cnt) ? rd_dat : '0;
    acc_n   = acc_q + SUM_W'(din_i) - SUM_W'(old_dat);
    rnd_add = '0;
    if (ROUND != 0 && win_q != '0) begin
      rnd_add = (SUM_W+1)'(1) << (win_q - WIN_W'(1));
    end
    avg_sum = {1'b0, acc_n} + rnd_add;
  end

  // Next state: clear/window change beat a sample update; otherwise accumulate on the strobe.
  always_comb begin
    acc_d         = acc_q;
    wr_ptr_d      = wr_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    win_d         = win_q;
    state_d       = state_q;
    dout_d        = dout_q;
    dout_full_d   = dout_full_q;
    dout_update_d = 1'b0;
    wr_vld        = 1'b0;
    if (avg_clr_i || win_chg) begin
      acc_d       = '0;
      wr_ptr_d    = '0;
      fill_cnt_d  = '0;
      win_d       = win_req;
      state_d     = ST_EMPTY;
      dout_d      = '0;
      dout_full_d = 1'b0;
    end else if (din_update_i) begin
      wr_vld        = 1'b1;
      acc_d         = acc_n;
      wr_ptr_d      = wr_ptr_q + MAX_LOG2'(1);
      fill_cnt_d    = (fill_cnt_q == n_cnt) ? fill_cnt_q : fill_cnt_q + CNT_W'(1);
      dout_d        = DATA_W'(avg_sum >> win_q);
      dout_update_d = 1'b1;
      dout_full_d   = dout_full_q | (fill_cnt_d == n_cnt);
      state_d       = (fill_cnt_d == n_cnt) ? ST_FULL : ST_FILL;
    end
  end

  // State and output registers; reset clears everything except the ring memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q         <= '0;
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      win_q         <= WIN_W'(clamp_win(0, MAX_LOG2));
      state_q       <= ST_EMPTY;
      dout_q        <= '0;
      dout_update_q <= 1'b0;
      dout_full_q   <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      win_q         <= win_d;
      state_q       <= state_d;
      dout_q        <= dout_d;
      dout_update_q <= dout_update_d;
      dout_full_q   <= dout_full_d;
    end
  end

  assign dout_o        = dout_q;
  assign dout_update_o = dout_update_q;
  assign dout_full_o   = dout_full_q;

endmodule
